// File: rtl/sub_serial_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master drives the request side and the slave returns status and result.
interface sub_serial_if #(parameter int W = 8);
  logic         start;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         bi;
  logic         busy;
  logic         done;
  logic [W-1:0] o;
  logic         bo;

  modport master (output start, x, y, bi, input busy, done, o, bo);
  modport slave  (input start, x, y, bi, output busy, done, o, bo);
endinterface

// File: rtl/sub_serial.sv
// Bit-serial subtractor: o = x - y - bi, one bit per clock, LSB first.
// Uses a single full-subtractor cell plus a borrow flop under a start/busy/done handshake.
module sub_serial #(
  parameter int W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  sub_serial_if.slave bus
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_xs;
  logic [W-1:0]   r_ys;
  logic [W-1:0]   r_res;
  logic [W-1:0]   r_o;
  logic           r_borrow;
  logic           r_bo;
  logic [CW-1:0]  r_cnt;
  logic           w_d;
  logic           w_borrowNext;
  logic           w_last;
  logic [W-1:0]   w_resNext;

  assign w_d          = r_xs[0] ^ r_ys[0] ^ r_borrow;
  assign w_borrowNext = (~r_xs[0] & r_ys[0]) | (~r_xs[0] & r_borrow) | (r_ys[0] & r_borrow);
  assign w_resNext    = {w_d, r_res[W-1:1]};
  assign w_last       = (r_state == RUN) && (r_cnt == CW'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Difference bits enter from the MSB side so bit 0 lands at o[0] after W shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xs     <= '0;
      r_ys     <= '0;
      r_res    <= '0;
      r_o      <= '0;
      r_borrow <= 1'b0;
      r_bo     <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == IDLE) begin
      if (bus.start) begin
        r_xs     <= bus.x;
        r_ys     <= bus.y;
        r_borrow <= bus.bi;
        r_cnt    <= '0;
      end
    end else if (r_state == RUN) begin
      r_xs     <= r_xs >> 1;
      r_ys     <= r_ys >> 1;
      r_borrow <= w_borrowNext;
      r_res    <= w_resNext;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        r_o  <= w_resNext;
        r_bo <= w_borrowNext;
      end
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
  assign bus.o    = r_o;
  assign bus.bo   = r_bo;

endmodule

// File: tb/tb_sub_serial.sv
// Self-checking bench for sub_serial: W=8 and W=2 instances compared against
// a plain-arithmetic model where {bo,o} is the (W+1)-bit value of x - y - bi.
module tb_sub_serial;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  sub_serial_if #(.W(8)) bus8 ();
  sub_serial_if #(.W(2)) bus2 ();

  sub_serial #(.W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  sub_serial #(.W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the (W+1)-bit difference carries the true borrow in its top bit.
  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
    return {1'b0, a} - {1'b0, b} - {8'd0, c};
  endfunction

  function automatic logic [2:0] model2(input logic [1:0] a, input logic [1:0] b, input logic c);
    return {1'b0, a} - {1'b0, b} - {2'd0, c};
  endfunction

  // Starts one W=8 operation and follows it to done, scrambling the operand
  // inputs after acceptance; outputs are sampled on falling edges.
  task automatic runOp8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        output int busyCycles, output bit gotDone,
                        output logic [7:0] ro, output logic rbo);
    @(negedge clk);
    bus8.start = 1'b1; bus8.x = a; bus8.y = b; bus8.bi = c;
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.x = 8'($urandom); bus8.y = 8'($urandom); bus8.bi = 1'($urandom);
    busyCycles = 0; gotDone = 1'b0; ro = '0; rbo = 1'b0;
    for (int k = 0; k < 40 && !gotDone; k++) begin
      if (bus8.done) begin
        gotDone = 1'b1; ro = bus8.o; rbo = bus8.bo;
      end else begin
        if (bus8.busy) busyCycles++;
        @(negedge clk);
      end
    end
  endtask

  task automatic runOp2(input logic [1:0] a, input logic [1:0] b, input logic c,
                        output bit gotDone, output logic [1:0] ro, output logic rbo);
    @(negedge clk);
    bus2.start = 1'b1; bus2.x = a; bus2.y = b; bus2.bi = c;
    @(negedge clk);
    bus2.start = 1'b0;
    bus2.x = 2'($urandom); bus2.y = 2'($urandom); bus2.bi = 1'($urandom);
    gotDone = 1'b0; ro = '0; rbo = 1'b0;
    for (int k = 0; k < 20 && !gotDone; k++) begin
      if (bus2.done) begin
        gotDone = 1'b1; ro = bus2.o; rbo = bus2.bo;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.x = '0; bus8.y = '0; bus8.bi = 1'b0;
    bus2.start = 1'b0; bus2.x = '0; bus2.y = '0; bus2.bi = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({bus8.busy, bus8.done, bus8.o, bus8.bo} !== 11'd0) begin
        failures++;
        $display("[TB] FAIL reset_idle cycle %0d: got busy=%b done=%b o=%h bo=%b, expected all 0",
                 i, bus8.busy, bus8.done, bus8.o, bus8.bo);
      end
    end
  endtask

  task automatic test_basic;
    int bc; bit gd; logic [7:0] ro; logic rbo;
    runOp8(8'd5, 8'd3, 1'b0, bc, gd, ro, rbo);
    checks++;
    if (!gd || bc !== 8) begin
      failures++;
      $display("[TB] FAIL basic_latency: got done=%b busy_cycles=%0d, expected done=1 busy_cycles=8", gd, bc);
    end
    checks++;
    if ({rbo, ro} !== 9'h002) begin
      failures++;
      $display("[TB] FAIL basic_result: got bo=%b o=%h, expected bo=0 o=02", rbo, ro);
    end
    @(negedge clk);
    checks++;
    if (bus8.done !== 1'b0 || bus8.busy !== 1'b0 || bus8.o !== 8'h02) begin
      failures++;
      $display("[TB] FAIL basic_done_pulse: got done=%b busy=%b o=%h, expected done=0 busy=0 o=02",
               bus8.done, bus8.busy, bus8.o);
    end
  endtask

  task automatic test_underflow;
    int bc; bit gd; logic [7:0] ro; logic rbo;
    runOp8(8'd3, 8'd5, 1'b0, bc, gd, ro, rbo);
    checks++;
    if (!gd || {rbo, ro} !== 9'h1FE) begin
      failures++;
      $display("[TB] FAIL underflow_3_5: got done=%b bo=%b o=%h, expected done=1 bo=1 o=fe", gd, rbo, ro);
    end
    runOp8(8'd0, 8'd0, 1'b1, bc, gd, ro, rbo);
    checks++;
    if (!gd || {rbo, ro} !== 9'h1FF) begin
      failures++;
      $display("[TB] FAIL underflow_0_0_bi: got done=%b bo=%b o=%h, expected done=1 bo=1 o=ff", gd, rbo, ro);
    end
  endtask

  task automatic test_ignored_start;
    int doneCount; int busyAfter;
    @(negedge clk);
    bus8.start = 1'b1; bus8.x = 8'hFF; bus8.y = 8'h00; bus8.bi = 1'b0;
    @(negedge clk);
    doneCount = 0;
    // Keep hammering start with changing operands until done shows up.
    for (int k = 0; k < 40 && doneCount == 0; k++) begin
      if (bus8.done) begin
        doneCount++;
        checks++;
        if ({bus8.bo, bus8.o} !== 9'h0FF) begin
          failures++;
          $display("[TB] FAIL ignored_start_result: got bo=%b o=%h, expected bo=0 o=ff", bus8.bo, bus8.o);
        end
      end else begin
        bus8.start = 1'b1; bus8.x = (k == 0) ? 8'd1 : 8'($urandom);
        bus8.y = (k == 0) ? 8'd1 : 8'($urandom);
        @(negedge clk);
      end
    end
    bus8.start = 1'b0;
    busyAfter = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus8.done) doneCount++;
      if (bus8.busy) busyAfter++;
    end
    checks++;
    if (doneCount !== 1 || busyAfter !== 0) begin
      failures++;
      $display("[TB] FAIL ignored_start_single: got done_pulses=%0d busy_after=%0d, expected 1 and 0",
               doneCount, busyAfter);
    end
    checks++;
    if (bus8.o !== 8'hFF) begin
      failures++;
      $display("[TB] FAIL ignored_start_hold: got o=%h, expected ff", bus8.o);
    end
  endtask

  task automatic test_reset_midop;
    int bc; bit gd; logic [7:0] ro; logic rbo; int doneSeen;
    @(negedge clk);
    bus8.start = 1'b1; bus8.x = 8'h80; bus8.y = 8'h01; bus8.bi = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus8.busy, bus8.done, bus8.o, bus8.bo} !== 11'd0) begin
      failures++;
      $display("[TB] FAIL reset_midop_async: got busy=%b done=%b o=%h bo=%b, expected all 0",
               bus8.busy, bus8.done, bus8.o, bus8.bo);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    doneSeen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus8.done || bus8.busy) doneSeen++;
    end
    checks++;
    if (doneSeen !== 0 || bus8.o !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_midop_quiet: got activity=%0d o=%h, expected 0 and 00", doneSeen, bus8.o);
    end
    runOp8(8'd10, 8'd4, 1'b0, bc, gd, ro, rbo);
    checks++;
    if (!gd || {rbo, ro} !== 9'h006) begin
      failures++;
      $display("[TB] FAIL reset_midop_recover: got done=%b bo=%b o=%h, expected done=1 bo=0 o=06", gd, rbo, ro);
    end
  endtask

  task automatic test_exhaustive_w2;
    bit gd; logic [1:0] ro; logic rbo; logic [4:0] v; logic [2:0] exp;
    for (int i = 0; i < 32; i++) begin
      v = 5'(i);
      exp = model2(v[4:3], v[2:1], v[0]);
      runOp2(v[4:3], v[2:1], v[0], gd, ro, rbo);
      checks++;
      if (!gd || {rbo, ro} !== exp) begin
        failures++;
        $display("[TB] FAIL w2_case x=%0d y=%0d bi=%0d: got done=%b {bo,o}=%b, expected %b",
                 v[4:3], v[2:1], v[0], gd, {rbo, ro}, exp);
      end
    end
  endtask

  task automatic test_random_w8;
    int bc; bit gd; logic [7:0] ro; logic rbo; logic [7:0] a, b; logic c; logic [8:0] exp;
    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
      if (i == 0) begin a = 8'h00; b = 8'hFF; c = 1'b1; end
      if (i == 1) begin a = 8'hFF; b = 8'hFF; c = 1'b0; end
      exp = model8(a, b, c);
      runOp8(a, b, c, bc, gd, ro, rbo);
      checks++;
      if (!gd || bc !== 8 || {rbo, ro} !== exp) begin
        failures++;
        $display("[TB] FAIL random_w8 x=%h y=%h bi=%b: got done=%b busy_cycles=%0d {bo,o}=%h, expected 1/8/%h",
                 a, b, c, gd, bc, {rbo, ro}, exp);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_underflow();
    test_ignored_start();
    test_reset_midop();
    test_exhaustive_w2();
    test_random_w8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
